// File: rtl/mul_sequencer.sv
// Iterative radix-2 shift-add multiplier for DLX MULT/MULTU, with its own sequencing FSM.
// Optional early termination on an exhausted multiplier: define MUL_SEQ_EARLY_TERM_EN.
module mul_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mulSigned,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] productLo,
  output logic [WIDTH-1:0] productHi
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   counter;
  logic               neg_res;

  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] result;
  logic               last_iter;

  // NOTE: every signal driven here gets a value on every path, so no latches are inferred.
  always_comb begin
    mag_a    = (mulSigned && opA[WIDTH-1]) ? -opA : opA;
    mag_b    = (mulSigned && opB[WIDTH-1]) ? -opB : opB;
    acc_next = mplier[0] ? acc + mcand : acc;
    result   = neg_res ? -acc_next : acc_next;
`ifdef MUL_SEQ_EARLY_TERM_EN
    last_iter = (counter == LAST_CNT) || ((mplier >> 1) == '0);
`else
    last_iter = (counter == LAST_CNT);
`endif
    // Freeze the pipeline in the start cycle itself, not one cycle later.
    stall = ((state == S_IDLE) && start) || (state == S_RUN);
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the datapath registers are reset too; the products must read 0 after any reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      productLo <= '0;
      productHi <= '0;
      mcand     <= '0;
      acc       <= '0;
      mplier    <= '0;
      counter   <= '0;
      neg_res   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand   <= {{WIDTH{1'b0}}, mag_a};
            mplier  <= mag_b;
            neg_res <= mulSigned & (opA[WIDTH-1] ^ opB[WIDTH-1]);
            acc     <= '0;
            counter <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end
        end
        S_RUN: begin
          acc     <= acc_next;
          mcand   <= mcand << 1;
          mplier  <= mplier >> 1;
          counter <= counter + CNT_W'(1);
          if (last_iter) begin
            {productHi, productLo} <= result;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // A start seen here is dropped; the pipeline re-presents it once unfrozen.
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_sequencer.sv
// Directed self-checking bench for mul_sequencer: latency, products, abort and back-to-back starts.
`timescale 1ns/1ps
module tb_mul_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        mulSigned;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] productLo;
  logic [31:0] productHi;

  int tests;
  int fails;

  mul_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .mulSigned (mulSigned),
    .opA       (opA),
    .opB       (opB),
    .stall     (stall),
    .busy      (busy),
    .done      (done),
    .productLo (productLo),
    .productHi (productHi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected cycle (relative to the start cycle) at which done pulses.
  function automatic int exp_lat(input logic sgn, input logic [31:0] b);
`ifdef MUL_SEQ_EARLY_TERM_EN
    logic [31:0] mag;
    int n;
    mag = (sgn && b[31]) ? -b : b;
    n = 1;
    for (int i = 0; i < 32; i++) if (mag[i]) n = i + 1;
    return n + 1;
`else
    return 33;
`endif
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mulSigned = 1'b0; opA = '0; opB = '0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
    tests++; if ({productHi, productLo} !== 64'h0) begin
      fails++; $display("FAIL reset_product: got %h expected 0", {productHi, productLo});
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One multiply: start in cycle 0, scramble operands afterwards, check timing and result.
  task automatic do_mul(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp_prod, input int exp_done);
    int cyc;
    bit seen, stall_ok, busy_ok;
    @(negedge clk);
    start = 1'b1; mulSigned = sgn; opA = a; opB = b;
    #1;
    tests++; if (stall !== 1'b1) begin fails++; $display("FAIL %s_stall_start: got %b expected 1", name, stall); end
    cyc = 0; seen = 0; stall_ok = 1; busy_ok = 1;
    while (!seen && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1;
      else begin
        if (stall !== 1'b1) stall_ok = 0;
        if (busy !== 1'b1) busy_ok = 0;
      end
      if (cyc == 1) begin start = 1'b0; mulSigned = ~sgn; opA = ~a; opB = ~b; end
    end
    tests++;
    if (!seen) begin
      fails++; $display("FAIL %s_timeout: no done within %0d cycles, expected at %0d", name, cyc, exp_done);
    end else begin
      if (cyc != exp_done) begin fails++; $display("FAIL %s_latency: got %0d expected %0d", name, cyc, exp_done); end
      tests++; if (!stall_ok) begin fails++; $display("FAIL %s_stall_run: stall dropped in RUN, expected 1", name); end
      tests++; if (!busy_ok) begin fails++; $display("FAIL %s_busy_run: busy dropped in RUN, expected 1", name); end
      tests++; if (stall !== 1'b0 || busy !== 1'b0) begin
        fails++; $display("FAIL %s_done_flags: got stall=%b busy=%b expected 0 0", name, stall, busy);
      end
      tests++; if ({productHi, productLo} !== exp_prod) begin
        fails++; $display("FAIL %s_product: got %h expected %h", name, {productHi, productLo}, exp_prod);
      end
      @(negedge clk);
      tests++; if (done !== 1'b0 || {productHi, productLo} !== exp_prod) begin
        fails++; $display("FAIL %s_after_done: got done=%b prod=%h expected 0 %h", name, done,
                          {productHi, productLo}, exp_prod);
      end
    end
  endtask

  task automatic test_basic();
    do_mul("multu_3x5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, exp_lat(1'b0, 32'd5));
    do_mul("mult_m3x5", 1'b1, 32'hFFFF_FFFD, 32'd5, 64'hFFFF_FFFF_FFFF_FFF1, exp_lat(1'b1, 32'd5));
    do_mul("multu_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001,
           exp_lat(1'b0, 32'hFFFF_FFFF));
    do_mul("mult_m1xm1", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001,
           exp_lat(1'b1, 32'hFFFF_FFFF));
    do_mul("mult_minxm1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000,
           exp_lat(1'b1, 32'hFFFF_FFFF));
    do_mul("mult_7xm2", 1'b1, 32'd7, 32'hFFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFF2, exp_lat(1'b1, 32'hFFFF_FFFE));
    do_mul("multu_zero", 1'b0, 32'd0, 32'd0, 64'h0, exp_lat(1'b0, 32'd0));
  endtask

  task automatic test_early_term();
`ifdef MUL_SEQ_EARLY_TERM_EN
    do_mul("multu_7x2", 1'b0, 32'd7, 32'd2, 64'd14, 3);
`else
    do_mul("multu_7x2", 1'b0, 32'd7, 32'd2, 64'd14, 33);
`endif
  endtask

  task automatic test_abort();
    int cyc;
    bit seen_done;
    seen_done = 0;
    @(negedge clk);
    start = 1'b1; mulSigned = 1'b0; opA = 32'd3; opB = 32'h8000_0001;
    for (cyc = 1; cyc <= 21; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) seen_done = 1;
      if (cyc == 1) start = 1'b0;
      if (cyc == 10) begin
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL abort_busy_c10: got %b expected 1", busy); end
        start = 1'b1; opA = 32'd7; opB = 32'd9;
      end
      if (cyc == 11) start = 1'b0;
      if (cyc == 20) begin
        reset = 1'b1;
        #1;
        tests++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin
          fails++; $display("FAIL abort_flags: got busy=%b stall=%b done=%b expected 0 0 0", busy, stall, done);
        end
        tests++; if ({productHi, productLo} !== 64'h0) begin
          fails++; $display("FAIL abort_product: got %h expected 0", {productHi, productLo});
        end
      end
      if (cyc == 21) reset = 1'b0;
    end
    tests++; if (seen_done) begin fails++; $display("FAIL abort_no_done: got done pulse, expected none"); end
    do_mul("abort_restart", 1'b0, 32'd6, 32'd7, 64'd42, exp_lat(1'b0, 32'd7));
  endtask

  // start held high throughout: the DONE-cycle start is dropped, resampled one cycle later.
  task automatic test_back_to_back();
    int cyc, first, second;
    bit stall_done_ok;
    first = -1; second = -1; stall_done_ok = 1;
    @(negedge clk);
    start = 1'b1; mulSigned = 1'b0; opA = 32'd3; opB = 32'h8000_0000;
    for (cyc = 1; cyc <= 80 && second < 0; cyc++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        if (stall !== 1'b0) stall_done_ok = 0;
        if (first < 0) first = cyc; else second = cyc;
      end
      if (first > 0 && cyc == first + 1 && stall !== 1'b1) stall_done_ok = 0;
    end
    start = 1'b0;
    tests++; if (first != 33) begin fails++; $display("FAIL b2b_first: got %0d expected 33", first); end
    tests++; if (second != 67) begin fails++; $display("FAIL b2b_second: got %0d expected 67", second); end
    tests++; if (!stall_done_ok) begin fails++; $display("FAIL b2b_stall: stall wrong around DONE"); end
    tests++; if ({productHi, productLo} !== 64'h0000_0001_8000_0000) begin
      fails++; $display("FAIL b2b_product: got %h expected 0000000180000000", {productHi, productLo});
    end
    @(negedge clk);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_basic();
    test_early_term();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
